register_file_mp: RTL and testbench

- Parametrised successor of the 32x32 MIPS register bank, for the pipelined core.
- Provides NUM_RD combinational read ports and two write ports: A for ALU writeback, B for load writeback.
- Optional write-to-read bypass.
- Per-register busy scoreboard: set at issue, cleared at writeback, so decode can detect RAW hazards.
- Sits between decode (reads, issue) and the writeback stages.

---
 rtl/mips_pkg.sv | 18 +
 rtl/reg_scoreboard.sv | 71 +++++++
 rtl/register_file_mp.sv | 100 ++++++++++
 tb/tb_register_file_mp.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants and helpers for the MIPS pipelined-core register file.
package mips_pkg;

    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned ADDR_W_DEF  = 5;

    localparam int unsigned REG_ZERO    = 0;
    localparam int unsigned REG_SP      = 29;
    localparam int unsigned REG_FP      = 30;

    localparam int unsigned SP_INIT_DEF = 65536;

    // Low bit of port `port` within a flat bus of `width`-bit lanes.
    function automatic int unsigned slice_lo(input int unsigned port, input int unsigned width);
        return port * width;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits: set at issue, cleared at writeback, looked up per read port.
module reg_scoreboard
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned BYPASS = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_issue_valid,
    input  logic [ADDR_W-1:0]        i_issue_rg,
    input  logic                     i_wr_a_en,
    input  logic [ADDR_W-1:0]        i_wr_a_rg,
    input  logic                     i_wr_b_en,
    input  logic [ADDR_W-1:0]        i_wr_b_rg,
    input  logic [NUM_RD*ADDR_W-1:0] i_rd_rg,
    output logic [NUM_RD-1:0]        o_rd_busy,
    output logic                     o_any_busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_busy_nxt;

    // Next busy vector: issue beats a same-cycle writeback; register 0 never busy.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int unsigned r = 1; r < DEPTH; r++) begin
            if (i_issue_valid && (i_issue_rg == ADDR_W'(r))) begin
                w_busy_nxt[r] = 1'b1;
            end else if ((i_wr_a_en && (i_wr_a_rg == ADDR_W'(r))) ||
                         (i_wr_b_en && (i_wr_b_rg == ADDR_W'(r)))) begin
                w_busy_nxt[r] = 1'b0;
            end
        end
        w_busy_nxt[REG_ZERO] = 1'b0;
    end

    // Busy register with synchronous clear.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // Per-port lookup; with bypass a result landing this cycle is no longer pending.
    always_comb begin
        o_rd_busy = '0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            logic [ADDR_W-1:0] w_addr;
            logic              w_wr_hit;
            w_addr   = i_rd_rg[slice_lo(k, ADDR_W) +: ADDR_W];
            w_wr_hit = (i_wr_a_en && (i_wr_a_rg == w_addr)) ||
                       (i_wr_b_en && (i_wr_b_rg == w_addr));
            if (w_addr != '0) begin
                if (BYPASS != 0) begin
                    o_rd_busy[k] = r_busy[w_addr] & ~w_wr_hit;
                end else begin
                    o_rd_busy[k] = r_busy[w_addr];
                end
            end
        end
    end

    assign o_any_busy = |r_busy;

endmodule

// File: rtl/register_file_mp.sv
// Multi-ported MIPS register file: NUM_RD combinational reads, two write ports
// (A = ALU writeback, B = load writeback, A wins on collision), optional
// write-to-read bypass and a RAW-hazard busy scoreboard.
module register_file_mp
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned NUM_RD  = 2,
    parameter int unsigned BYPASS  = 1,
    parameter int unsigned SP_IDX  = REG_SP,
    parameter int unsigned FP_IDX  = REG_FP,
    parameter int unsigned SP_INIT = SP_INIT_DEF
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [NUM_RD*ADDR_W-1:0] ReadRg,
    output logic [NUM_RD*DATA_W-1:0] ReadData,
    output logic [NUM_RD-1:0]        ReadBusy,
    input  logic [ADDR_W-1:0]        WriteRgA,
    input  logic [DATA_W-1:0]        WriteDataA,
    input  logic                     RegWriteA,
    input  logic [ADDR_W-1:0]        WriteRgB,
    input  logic [DATA_W-1:0]        WriteDataB,
    input  logic                     RegWriteB,
    input  logic [ADDR_W-1:0]        IssueRg,
    input  logic                     IssueValid,
    output logic                     AnyBusy
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic              w_wr_a;
    logic              w_wr_b;

    assign w_wr_a = RegWriteA && (WriteRgA != '0);
    assign w_wr_b = RegWriteB && (WriteRgB != '0);

    // Storage: reset loads SP/FP, port B written first so port A wins a collision.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if ((i == SP_IDX) || (i == FP_IDX)) begin
                    r_regs[i] <= DATA_W'(SP_INIT);
                end else begin
                    r_regs[i] <= '0;
                end
            end
        end else begin
            if (w_wr_b) begin
                r_regs[WriteRgB] <= WriteDataB;
            end
            if (w_wr_a) begin
                r_regs[WriteRgA] <= WriteDataA;
            end
        end
    end

    // Read muxing: A bypass, then B bypass, then stored value; register 0 reads 0.
    always_comb begin
        ReadData = '0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            logic [ADDR_W-1:0] w_addr;
            logic [DATA_W-1:0] w_data;
            w_addr = ReadRg[slice_lo(k, ADDR_W) +: ADDR_W];
            w_data = r_regs[w_addr];
            if ((BYPASS != 0) && !Reset) begin
                if (w_wr_a && (WriteRgA == w_addr)) begin
                    w_data = WriteDataA;
                end else if (w_wr_b && (WriteRgB == w_addr)) begin
                    w_data = WriteDataB;
                end
            end
            if (w_addr == '0) begin
                w_data = '0;
            end
            ReadData[slice_lo(k, DATA_W) +: DATA_W] = w_data;
        end
    end

    reg_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD),
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .i_clk         (Clock),
        .i_rst         (Reset),
        .i_issue_valid (IssueValid),
        .i_issue_rg    (IssueRg),
        .i_wr_a_en     (RegWriteA),
        .i_wr_a_rg     (WriteRgA),
        .i_wr_b_en     (RegWriteB),
        .i_wr_b_rg     (WriteRgB),
        .i_rd_rg       (ReadRg),
        .o_rd_busy     (ReadBusy),
        .o_any_busy    (AnyBusy)
    );

endmodule

// File: tb/tb_register_file_mp.sv
// Scoreboard bench: two instances (bypass on / off) share stimulus; the driver
// queues expected read results, a monitor pops and compares them each cycle.
module tb_register_file_mp;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [9:0]  ReadRg;
    logic [4:0]  WriteRgA, WriteRgB, IssueRg;
    logic [31:0] WriteDataA, WriteDataB;
    logic        RegWriteA, RegWriteB, IssueValid;

    logic [63:0] rd_data1, rd_data0;
    logic [1:0]  rd_busy1, rd_busy0;
    logic        any1, any0;

    always #5 Clock = ~Clock;

    register_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1)) dut1 (
        .Clock(Clock), .Reset(Reset), .ReadRg(ReadRg), .ReadData(rd_data1),
        .ReadBusy(rd_busy1), .WriteRgA(WriteRgA), .WriteDataA(WriteDataA),
        .RegWriteA(RegWriteA), .WriteRgB(WriteRgB), .WriteDataB(WriteDataB),
        .RegWriteB(RegWriteB), .IssueRg(IssueRg), .IssueValid(IssueValid),
        .AnyBusy(any1));

    register_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(0)) dut0 (
        .Clock(Clock), .Reset(Reset), .ReadRg(ReadRg), .ReadData(rd_data0),
        .ReadBusy(rd_busy0), .WriteRgA(WriteRgA), .WriteDataA(WriteDataA),
        .RegWriteA(RegWriteA), .WriteRgB(WriteRgB), .WriteDataB(WriteDataB),
        .RegWriteB(RegWriteB), .IssueRg(IssueRg), .IssueValid(IssueValid),
        .AnyBusy(any0));

    typedef struct {
        string       tag;
        int          dut;
        int          port;
        logic [31:0] data;
        logic        busy;
        logic        any;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic drive(input logic rst,
                         input logic wa_en, input logic [4:0] wa, input logic [31:0] da,
                         input logic wb_en, input logic [4:0] wb, input logic [31:0] db,
                         input logic iv, input logic [4:0] ir,
                         input logic [4:0] r0, input logic [4:0] r1);
        @(negedge Clock);
        Reset = rst;
        RegWriteA = wa_en; WriteRgA = wa; WriteDataA = da;
        RegWriteB = wb_en; WriteRgB = wb; WriteDataB = db;
        IssueValid = iv;   IssueRg = ir;
        ReadRg = {r1, r0};
        #1;
    endtask

    task automatic idle(input logic [4:0] r0, input logic [4:0] r1);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, r0, r1);
    endtask

    // Expected per port: (bypass-on data, busy) and (bypass-off data, busy); AnyBusy shared.
    task automatic expect_rd(input string tag,
                             input logic [31:0] p0d1, input logic p0b1,
                             input logic [31:0] p0d0, input logic p0b0,
                             input logic [31:0] p1d1, input logic p1b1,
                             input logic [31:0] p1d0, input logic p1b0,
                             input logic any);
        q.push_back('{tag, 1, 0, p0d1, p0b1, any});
        q.push_back('{tag, 0, 0, p0d0, p0b0, any});
        q.push_back('{tag, 1, 1, p1d1, p1b1, any});
        q.push_back('{tag, 0, 1, p1d0, p1b0, any});
    endtask

    // Monitor: read outputs are combinational, so compare mid-cycle after the driver settles.
    initial begin
        forever begin
            @(negedge Clock);
            #2;
            while (q.size() > 0) begin
                exp_t e;
                logic [31:0] ad;
                logic        ab, aa;
                e = q.pop_front();
                if (e.dut == 1) begin
                    ad = rd_data1[e.port*32 +: 32]; ab = rd_busy1[e.port]; aa = any1;
                end else begin
                    ad = rd_data0[e.port*32 +: 32]; ab = rd_busy0[e.port]; aa = any0;
                end
                n_vec++;
                if (ad !== e.data || ab !== e.busy || aa !== e.any) begin
                    n_miss++;
                    $display("FAIL %s bypass=%0d port=%0d: got data=%h busy=%b any=%b, want data=%h busy=%b any=%b",
                             e.tag, e.dut, e.port, ad, ab, aa, e.data, e.busy, e.any);
                end
            end
        end
    end

    localparam logic [31:0] SPV = 32'd65536;
    localparam logic [31:0] DB  = 32'hDEADBEEF;

    initial begin
        Reset = 1'b1; ReadRg = '0;
        RegWriteA = 1'b0; WriteRgA = '0; WriteDataA = '0;
        RegWriteB = 1'b0; WriteRgB = '0; WriteDataB = '0;
        IssueValid = 1'b0; IssueRg = '0;

        drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
        drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);

        idle(5'd0, 5'd29);
        expect_rd("rst_r0_r29", 0, 0, 0, 0, SPV, 0, SPV, 0, 0);
        idle(5'd30, 5'd5);
        expect_rd("rst_r30_r5", SPV, 0, SPV, 0, 0, 0, 0, 0, 0);

        drive(1'b0, 1'b1, 5'd8, DB, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd8, 5'd5);
        expect_rd("wrA8_same", DB, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(5'd8, 5'd0);
        expect_rd("wrA8_next", DB, 0, DB, 0, 0, 0, 0, 0, 0);

        drive(1'b0, 1'b1, 5'd9, 32'h11, 1'b1, 5'd9, 32'h22, 1'b0, 5'd0, 5'd9, 5'd9);
        expect_rd("collide_same", 32'h11, 0, 0, 0, 32'h11, 0, 0, 0, 0);
        idle(5'd9, 5'd8);
        expect_rd("collide_next", 32'h11, 0, 32'h11, 0, DB, 0, DB, 0, 0);

        drive(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0, 5'd0);
        expect_rd("r0_wr_same", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(5'd0, 5'd9);
        expect_rd("r0_wr_next", 0, 0, 0, 0, 32'h11, 0, 32'h11, 0, 0);

        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 5'd12, 5'd9);
        expect_rd("issue12_same", 0, 0, 0, 0, 32'h11, 0, 32'h11, 0, 0);
        idle(5'd12, 5'd9);
        expect_rd("issue12_next", 0, 1, 0, 1, 32'h11, 0, 32'h11, 0, 1);

        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'h5, 1'b1, 5'd12, 5'd12, 5'd9);
        expect_rd("issue_wrB_same", 32'h5, 0, 0, 1, 32'h11, 0, 32'h11, 0, 1);
        idle(5'd12, 5'd9);
        expect_rd("issue_wrB_next", 32'h5, 1, 32'h5, 1, 32'h11, 0, 32'h11, 0, 1);

        drive(1'b0, 1'b1, 5'd12, 32'h6, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd12, 5'd9);
        expect_rd("wrA12_same", 32'h6, 0, 32'h5, 1, 32'h11, 0, 32'h11, 0, 1);
        idle(5'd12, 5'd9);
        expect_rd("wrA12_next", 32'h6, 0, 32'h6, 0, 32'h11, 0, 32'h11, 0, 0);

        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 5'd12, 5'd3);
        expect_rd("wrB3_same", 32'h6, 0, 32'h6, 0, 32'h33, 0, 0, 0, 0);
        idle(5'd3, 5'd3);
        expect_rd("wrB3_next", 32'h33, 0, 32'h33, 0, 32'h33, 0, 32'h33, 0, 0);

        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 5'd12, 5'd8);
        expect_rd("issue12_again", 32'h6, 0, 32'h6, 0, DB, 0, DB, 0, 0);

        drive(1'b1, 1'b1, 5'd8, 32'h77, 1'b0, 5'd0, 32'h0, 1'b1, 5'd13, 5'd8, 5'd12);
        expect_rd("rst_cycle", DB, 0, DB, 0, 32'h6, 1, 32'h6, 1, 1);
        idle(5'd8, 5'd29);
        expect_rd("post_rst_a", 0, 0, 0, 0, SPV, 0, SPV, 0, 0);
        idle(5'd12, 5'd13);
        expect_rd("post_rst_b", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        idle(5'd0, 5'd0);
        @(negedge Clock);
        #3;
        if (q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
